agu_loop_sched: RTL and testbench

//  Multi-pass address scheduler that sequences the HPU address-generation datapath.
//  - One start runs cfg_rep passes over the inclusive range [cfg_ini, cfg_fin].
//  - Addresses leave on a valid/ready stream that feeds the memory read port.
//  - Sits between the command decoder (config + start) and the BRAM read side;

---
 rtl/hpu_pkg.sv | 13 +
 rtl/agu_loop_sched_loop_cnt.sv | 29 ++
 rtl/agu_loop_sched.sv | 125 ++++++++++++
 tb/tb_agu_loop_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared types and default widths for the HPU address-generation blocks.
package hpu_pkg;

  localparam int ADDR_W = 32;
  localparam int REP_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/agu_loop_sched_loop_cnt.sv
// Loadable up-counter with a terminal-value compare; used for both the
// address (inner) and pass (outer) loops of agu_loop_sched.
module loop_cnt #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         inc,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] cnt,
  output logic         at_max
);

  // load wins over inc so a pass restart never double-steps
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == max_val);

endmodule

// File: rtl/agu_loop_sched.sv
// Multi-pass address scheduler: one start issues cfg_rep passes over
// [cfg_ini, cfg_fin] on a valid/ready stream, then pulses done.
module agu_loop_sched
  import hpu_pkg::*;
#(
  parameter int W  = ADDR_W,
  parameter int CW = REP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  cfg_ini,
  input  logic [W-1:0]  cfg_fin,
  input  logic [CW-1:0] cfg_rep,
  input  logic          start,
  input  logic          addr_ready,
  output logic          addr_valid,
  output logic [W-1:0]  addr,
  output logic          pass_last,
  output logic          addr_last,
  output logic [CW-1:0] pass_idx,
  output logic          busy,
  output logic          done,
  output logic          err,
  output sched_state_t  dbg_state
);

  // Stream handshake: a beat transfers on a cycle where addr_valid and
  // addr_ready are both high; addr_valid never depends on addr_ready, and
  // addr plus all flags are held stable while addr_valid is high and
  // addr_ready is low.

  sched_state_t  state_q, state_d;
  logic [W-1:0]  ini_q, fin_q;
  logic [CW-1:0] rep_q;
  logic          err_q;

  logic          accept, bad_empty, bad_order, hs;
  logic          in_load, in_inc, in_max;
  logic          out_load, out_inc, out_max;
  logic [W-1:0]  in_cnt, in_load_val;
  logic [CW-1:0] out_cnt;

  assign accept    = (state_q == S_IDLE) && start;
  assign bad_empty = (cfg_rep == '0);
  assign bad_order = (cfg_fin < cfg_ini);
  assign hs        = addr_valid && addr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (bad_empty || bad_order) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (hs && addr_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ini_q   <= '0;
      fin_q   <= '0;
      rep_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ini_q <= cfg_ini;
        fin_q <= cfg_fin;
        rep_q <= cfg_rep;
        // an empty pass count is a clean no-op, not an error
        err_q <= !bad_empty && bad_order;
      end
    end
  end

  // Inner loop restarts at ini at the end of every pass except the last.
  assign in_load     = accept || (hs && in_max && !out_max);
  assign in_load_val = accept ? cfg_ini : ini_q;
  assign in_inc      = hs && !in_max;

  loop_cnt #(.N(W)) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (in_load),
    .load_val (in_load_val),
    .inc      (in_inc),
    .max_val  (fin_q),
    .cnt      (in_cnt),
    .at_max   (in_max)
  );

  assign out_load = accept;
  assign out_inc  = hs && in_max && !out_max;

  loop_cnt #(.N(CW)) u_pass_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (out_load),
    .load_val ('0),
    .inc      (out_inc),
    .max_val  (rep_q - 1'b1),
    .cnt      (out_cnt),
    .at_max   (out_max)
  );

  assign addr_valid = (state_q == S_RUN);
  assign addr       = in_cnt;
  assign pass_idx   = out_cnt;
  assign pass_last  = addr_valid && in_max;
  assign addr_last  = pass_last && out_max;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = done && err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_agu_loop_sched.sv
// Directed bench for agu_loop_sched: multi-pass streams, stalls, rejects,
// ignored starts and mid-run reset.
module tb_agu_loop_sched;
  import hpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cfg_ini, cfg_fin;
  logic [15:0]  cfg_rep;
  logic         start, addr_ready;
  logic         addr_valid, pass_last, addr_last, busy, done, err;
  logic [31:0]  addr;
  logic [15:0]  pass_idx;
  sched_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  agu_loop_sched dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_ini    (cfg_ini),
    .cfg_fin    (cfg_fin),
    .cfg_rep    (cfg_rep),
    .start      (start),
    .addr_ready (addr_ready),
    .addr_valid (addr_valid),
    .addr       (addr),
    .pass_last  (pass_last),
    .addr_last  (addr_last),
    .pass_idx   (pass_idx),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present config with a one-cycle start; returns just after the sampling edge.
  task automatic go(input logic [31:0] ini, input logic [31:0] fin, input logic [15:0] rep);
    cfg_ini = ini;
    cfg_fin = fin;
    cfg_rep = rep;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Follow a started stream to completion. rpat gives addr_ready per cycle
  // (bit cyc%4). With poke set, start is pulsed mid-run and during DONE with
  // different config, which must be ignored.
  task automatic run_stream(input logic [31:0] ini, input logic [31:0] fin,
                            input logic [15:0] rep, input logic [3:0] rpat,
                            input bit poke, input string nm);
    logic [31:0] ea;
    logic [15:0] ep;
    int total, nhs, cyc;
    ea    = ini;
    ep    = 0;
    total = (int'(fin - ini) + 1) * int'(rep);
    nhs   = 0;
    cyc   = 0;
    while (nhs < total && cyc < 200) begin
      addr_ready = rpat[cyc % 4];
      if (poke && cyc == 2) begin
        cfg_ini = 32'h100; cfg_fin = 32'h1ff; cfg_rep = 16'd7; start = 1'b1;
      end
      chk({nm, ".valid"}, {31'd0, addr_valid}, 32'd1);
      chk({nm, ".addr"}, addr, ea);
      chk({nm, ".pass_idx"}, {16'd0, pass_idx}, {16'd0, ep});
      chk({nm, ".pass_last"}, {31'd0, pass_last}, {31'd0, ea == fin});
      chk({nm, ".addr_last"}, {31'd0, addr_last}, {31'd0, (ea == fin) && (ep == rep - 16'd1)});
      tick();
      start = 1'b0;
      if (addr_ready) begin
        nhs++;
        if (ea != fin) ea = ea + 32'd1;
        else begin ea = ini; ep = ep + 16'd1; end
      end
      cyc++;
    end
    chk({nm, ".handshakes"}, nhs, total);
    addr_ready = 1'b1;
    chk({nm, ".done"}, {31'd0, done}, 32'd1);
    chk({nm, ".err"}, {31'd0, err}, 32'd0);
    chk({nm, ".valid_in_done"}, {31'd0, addr_valid}, 32'd0);
    chk({nm, ".busy_in_done"}, {31'd0, busy}, 32'd1);
    if (poke) begin
      cfg_ini = 32'h10; cfg_fin = 32'h20; cfg_rep = 16'd2; start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk({nm, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, ".busy_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, ".state_idle"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
    tick();
    chk({nm, ".no_restart"}, {31'd0, addr_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr_ready = 1'b1;
    cfg_ini = 32'd0; cfg_fin = 32'd0; cfg_rep = 16'd0;
    tick();
    tick();
    chk("rst.valid", {31'd0, addr_valid}, 32'd0);
    chk("rst.addr", addr, 32'd0);
    chk("rst.pass_idx", {16'd0, pass_idx}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();

    // Single pass, always ready: 4,5,6,7 then done.
    go(32'd4, 32'd7, 16'd1);
    run_stream(32'd4, 32'd7, 16'd1, 4'b1111, 1'b0, "c1");

    // Three passes of 0..2.
    go(32'd0, 32'd2, 16'd3);
    run_stream(32'd0, 32'd2, 16'd3, 4'b1111, 1'b0, "c2");

    // Back-pressure: ready 1,0,0,1 repeating (bit0 first).
    go(32'd4, 32'd7, 16'd1);
    run_stream(32'd4, 32'd7, 16'd1, 4'b1001, 1'b0, "c3");

    // Empty pass count: done without err, no addresses.
    go(32'd0, 32'd5, 16'd0);
    chk("rep0.valid", {31'd0, addr_valid}, 32'd0);
    chk("rep0.done", {31'd0, done}, 32'd1);
    chk("rep0.err", {31'd0, err}, 32'd0);
    tick();
    chk("rep0.done_pulse", {31'd0, done}, 32'd0);
    chk("rep0.busy", {31'd0, busy}, 32'd0);

    // Reversed range: done with err.
    go(32'd5, 32'd3, 16'd2);
    chk("rev.valid", {31'd0, addr_valid}, 32'd0);
    chk("rev.done", {31'd0, done}, 32'd1);
    chk("rev.err", {31'd0, err}, 32'd1);
    tick();
    chk("rev.err_pulse", {31'd0, err}, 32'd0);
    chk("rev.valid_after", {31'd0, addr_valid}, 32'd0);

    // Starts during RUN and DONE with new config are ignored.
    go(32'd20, 32'd23, 16'd2);
    run_stream(32'd20, 32'd23, 16'd2, 4'b1101, 1'b1, "c5");

    // Single-address range: every beat is pass_last.
    go(32'd9, 32'd9, 16'd3);
    run_stream(32'd9, 32'd9, 16'd3, 4'b1111, 1'b0, "one");

    // Range ending at the top of the address space.
    go(32'hffff_fffd, 32'hffff_ffff, 16'd2);
    run_stream(32'hffff_fffd, 32'hffff_ffff, 16'd2, 4'b0111, 1'b0, "top");

    // Reset after two beats of a three-pass run.
    go(32'd0, 32'd2, 16'd3);
    addr_ready = 1'b1;
    tick();
    tick();
    chk("mid.addr_before_rst", addr, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.valid", {31'd0, addr_valid}, 32'd0);
    chk("mid.addr", addr, 32'd0);
    chk("mid.pass_idx", {16'd0, pass_idx}, 32'd0);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk("mid.done", {31'd0, done}, 32'd0);
    chk("mid.err", {31'd0, err}, 32'd0);
    tick();
    chk("mid.no_done", {31'd0, done}, 32'd0);
    go(32'd4, 32'd7, 16'd1);
    run_stream(32'd4, 32'd7, 16'd1, 4'b1111, 1'b0, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
